trdb_encoder_ctrl: RTL and testbench

Control FSM that sequences the trace encoder's lifecycle: enable, disable, qualification windows, operating-mode changes and the resync timer. It produces the tc/lc status pulses (enc_enabled, enc_disabled, opmode_change, first_qualified, final_qualified, max_resync) consumed by the packet-format selector. It also owns the resync counter that the selector clears via its resync-reset request.

---
 rtl/trdb_encoder_ctrl.sv | 130 +++++++++++++
 tb/tb_trdb_encoder_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/trdb_encoder_ctrl.sv
// Trace encoder lifecycle controller: enable/disable, qualification windows, mode changes, resync timer.
// Define TRDB_RESYNC_CYCLES_EN to count resync in clock cycles instead of issued packets.
module trdb_encoder_ctrl #(
   parameter int unsigned CNT_W  = 16,
   parameter int unsigned MODE_W = 2
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              enable_i,
   input  logic [MODE_W-1:0] mode_i,
   input  logic [CNT_W-1:0]  resync_max_i,
   input  logic              valid_i,
   input  logic              qualified_i,
   input  logic              packet_valid_i,
   input  logic              resync_rst_i,
   output logic              active_o,
   output logic              tc_enc_enabled_o,
   output logic              tc_enc_disabled_o,
   output logic              tc_opmode_change_o,
   output logic              tc_first_qualified_o,
   output logic              lc_final_qualified_o,
   output logic              tc_max_resync_o
);

   typedef enum logic [1:0] {
      OFF,
      WAIT_QUAL,
      TRACING
   } state_e;

   state_e              state_q, state_d;
   logic                enable_q;
   logic [MODE_W-1:0]   mode_q, mode_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                enabled_q, enabled_d;
   logic                disabled_q, disabled_d;
   logic                opmode_q, opmode_d;
   logic                rise, fall, cnt_inc;
   logic                first_qual, final_qual;

   always_comb begin
      rise       = enable_i & ~enable_q;
      fall       = ~enable_i & enable_q;
      state_d    = state_q;
      enabled_d  = 1'b0;
      disabled_d = 1'b0;
      opmode_d   = 1'b0;
      first_qual = 1'b0;
      final_qual = 1'b0;
      mode_d     = mode_i;

      // A fall wins over any qualification event in the same cycle.
      unique case (state_q)
         OFF: begin
            if (rise) begin
               state_d   = WAIT_QUAL;
               enabled_d = 1'b1;
            end
         end
         WAIT_QUAL: begin
            if (fall) begin
               state_d    = OFF;
               disabled_d = 1'b1;
            end else if (valid_i && qualified_i && enable_i) begin
               state_d    = TRACING;
               first_qual = 1'b1;
            end
         end
         TRACING: begin
            if (fall) begin
               state_d    = OFF;
               disabled_d = 1'b1;
               final_qual = 1'b1;
            end else if (valid_i && !qualified_i && enable_i) begin
               state_d    = WAIT_QUAL;
               final_qual = 1'b1;
            end
         end
         default: state_d = OFF;
      endcase

      // Mode changes in OFF, the rise cycle or the fall cycle are absorbed silently.
      if ((state_q != OFF) && !fall && (mode_i != mode_q)) begin
         opmode_d = 1'b1;
      end

`ifdef TRDB_RESYNC_CYCLES_EN
      cnt_inc = (state_q == TRACING);
`else
      cnt_inc = (state_q == TRACING) && packet_valid_i;
`endif

      // Saturating compare also covers a threshold lowered below the current count.
      cnt_d = cnt_q;
      if ((state_d == OFF) || resync_rst_i) begin
         cnt_d = '0;
      end else if (cnt_inc && (cnt_q < resync_max_i)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= OFF;
         enable_q   <= 1'b0;
         mode_q     <= '0;
         cnt_q      <= '0;
         enabled_q  <= 1'b0;
         disabled_q <= 1'b0;
         opmode_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         enable_q   <= enable_i;
         mode_q     <= mode_d;
         cnt_q      <= cnt_d;
         enabled_q  <= enabled_d;
         disabled_q <= disabled_d;
         opmode_q   <= opmode_d;
      end
   end

   assign active_o             = (state_q != OFF);
   assign tc_enc_enabled_o     = enabled_q;
   assign tc_enc_disabled_o    = disabled_q;
   assign tc_opmode_change_o   = opmode_q;
   assign tc_first_qualified_o = first_qual;
   assign lc_final_qualified_o = final_qual;
   assign tc_max_resync_o      = (resync_max_i != '0) && (cnt_q >= resync_max_i);

endmodule

// File: tb/tb_trdb_encoder_ctrl.sv
// Scoreboard bench for trdb_encoder_ctrl: directed lifecycle sequence followed by randomized traffic.
// Honours TRDB_RESYNC_CYCLES_EN the same way the design does.
module tb_trdb_encoder_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        enable_i = 1'b0;
   logic [1:0]  mode_i = '0;
   logic [15:0] resync_max_i = '0;
   logic        valid_i = 1'b0;
   logic        qualified_i = 1'b0;
   logic        packet_valid_i = 1'b0;
   logic        resync_rst_i = 1'b0;
   logic        active_o, tc_enc_enabled_o, tc_enc_disabled_o, tc_opmode_change_o;
   logic        tc_first_qualified_o, lc_final_qualified_o, tc_max_resync_o;

   trdb_encoder_ctrl #(.CNT_W(16), .MODE_W(2)) dut (
      .clk_i                (clk_i),
      .rst_ni               (rst_ni),
      .enable_i             (enable_i),
      .mode_i               (mode_i),
      .resync_max_i         (resync_max_i),
      .valid_i              (valid_i),
      .qualified_i          (qualified_i),
      .packet_valid_i       (packet_valid_i),
      .resync_rst_i         (resync_rst_i),
      .active_o             (active_o),
      .tc_enc_enabled_o     (tc_enc_enabled_o),
      .tc_enc_disabled_o    (tc_enc_disabled_o),
      .tc_opmode_change_o   (tc_opmode_change_o),
      .tc_first_qualified_o (tc_first_qualified_o),
      .lc_final_qualified_o (lc_final_qualified_o),
      .tc_max_resync_o      (tc_max_resync_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic active, en_p, dis_p, mode_p, first, final_q, max_r;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   fails  = 0;
   int   pushed = 0;
   int   popped = 0;

   // Reference model: is the encoder on, is a qualification window open, pending pulses, resync count.
   bit       m_on, m_window, m_en_p, m_dis_p, m_mode_p;
   bit [1:0] m_mode;
   int       m_cnt;

   task automatic modelReset();
      m_on = 0; m_window = 0; m_en_p = 0; m_dis_p = 0; m_mode_p = 0; m_mode = 0; m_cnt = 0;
   endtask

   task automatic checkOutput(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
      end
   endtask

   task automatic applyStimulus(input bit rst, input bit en, input bit [1:0] mode, input int rmax,
                                input bit vld, input bit qual, input bit pkt, input bit rrst);
      exp_t e;
      bit   turn_off, turn_on, counts;
      @(negedge clk_i);
      rst_ni = ~rst; enable_i = en; mode_i = mode; resync_max_i = 16'(rmax);
      valid_i = vld; qualified_i = qual; packet_valid_i = pkt; resync_rst_i = rrst;
      if (rst) modelReset();
      e.active  = m_on;
      e.en_p    = m_en_p;
      e.dis_p   = m_dis_p;
      e.mode_p  = m_mode_p;
      e.first   = m_on && !m_window && en && vld && qual;
      e.final_q = m_on && m_window && (!en || (vld && !qual));
      e.max_r   = (rmax != 0) && (m_cnt >= rmax);
      exp_q.push_back(e);
      pushed++;
      @(posedge clk_i);
      if (!rst) begin
         turn_off = m_on && !en;
         turn_on  = !m_on && en;
`ifdef TRDB_RESYNC_CYCLES_EN
         counts = m_window;
`else
         counts = m_window && pkt;
`endif
         m_en_p   = turn_on;
         m_dis_p  = turn_off;
         m_mode_p = m_on && !turn_off && (mode != m_mode);
         m_mode   = mode;
         if (turn_off || !m_on || rrst) m_cnt = 0;
         else if (counts && m_cnt < rmax) m_cnt = m_cnt + 1;
         if (turn_off) m_window = 0;
         else if (m_on && vld) m_window = qual;
         if (turn_off) m_on = 0;
         else if (turn_on) m_on = 1;
      end
   endtask

   // Monitor: every cycle the DUT presents its outputs, pop the oldest expectation and compare.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk_i);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            popped++;
            checkOutput("active_o", active_o, e.active);
            checkOutput("tc_enc_enabled_o", tc_enc_enabled_o, e.en_p);
            checkOutput("tc_enc_disabled_o", tc_enc_disabled_o, e.dis_p);
            checkOutput("tc_opmode_change_o", tc_opmode_change_o, e.mode_p);
            checkOutput("tc_first_qualified_o", tc_first_qualified_o, e.first);
            checkOutput("lc_final_qualified_o", lc_final_qualified_o, e.final_q);
            checkOutput("tc_max_resync_o", tc_max_resync_o, e.max_r);
         end
      end
   end

   initial begin
      bit       en, vld, qual, pkt, rrst, rst;
      bit [1:0] mode;
      int       rmax;
      modelReset();
      $display("[TB] directed lifecycle sequence");
      applyStimulus(1, 0, 0, 3, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 3, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 3, 0, 0, 0, 0);
      applyStimulus(0, 1, 0, 3, 0, 0, 0, 0);
      applyStimulus(0, 1, 0, 3, 0, 0, 0, 0);
      applyStimulus(0, 1, 0, 3, 1, 1, 0, 0);
      applyStimulus(0, 1, 0, 3, 1, 0, 0, 0);
      applyStimulus(0, 1, 0, 3, 1, 1, 0, 0);
      for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, 3, 0, 0, 1, 0);
      applyStimulus(0, 1, 0, 3, 0, 0, 0, 1);
      applyStimulus(0, 1, 0, 3, 0, 0, 0, 0);
      applyStimulus(0, 1, 0, 1, 0, 0, 1, 0);
      applyStimulus(0, 1, 0, 1, 0, 0, 0, 0);
      applyStimulus(0, 1, 2, 1, 0, 0, 0, 0);
      applyStimulus(0, 1, 2, 1, 0, 0, 0, 0);
      applyStimulus(0, 0, 1, 0, 1, 1, 1, 0);
      applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
      applyStimulus(0, 1, 1, 0, 0, 0, 0, 0);
      applyStimulus(0, 1, 1, 0, 1, 1, 0, 0);
      for (int i = 0; i < 6; i++) applyStimulus(0, 1, 1, 0, 0, 0, 1, 0);
      applyStimulus(1, 1, 1, 0, 0, 0, 0, 0);
      applyStimulus(0, 1, 1, 4, 0, 0, 0, 0);
      applyStimulus(0, 1, 1, 4, 0, 0, 0, 0);
      applyStimulus(0, 1, 1, 4, 1, 1, 0, 0);
      for (int i = 0; i < 6; i++) applyStimulus(0, 1, 1, 4, 0, 0, 0, 0);

      $display("[TB] randomized traffic");
      en = 1; mode = 1; rmax = 4;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(99) < 4) en = !en;
         if ($urandom_range(99) < 8) mode = 2'($urandom_range(3));
         if ($urandom_range(99) < 3) rmax = $urandom_range(0, 6);
         vld  = $urandom_range(99) < 65;
         qual = $urandom_range(99) < 50;
         pkt  = $urandom_range(99) < 50;
         rrst = $urandom_range(99) < 6;
         rst  = $urandom_range(999) < 8;
         applyStimulus(rst, en, mode, rmax, vld, qual, pkt, rrst);
      end
      @(negedge clk_i);
      @(negedge clk_i);
      checks++;
      if (popped != pushed) begin
         fails++;
         $display("[TB] FAIL scoreboard_drain: popped %0d expected %0d", popped, pushed);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
